// File: rtl/start_ctrl_pkg.sv
// start_ctrl_pkg: shared state encoding and default parameters for the start controller.
package start_ctrl_pkg;
    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int TIMEOUT_CYCLES_DEF  = 1024;
    localparam int CNT_W_DEF           = 8;
    typedef logic [2:0] state_t;
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;
endpackage

// File: rtl/debouncer.sv
// debouncer: 2-flop synchronizer plus stability counter; rise marks a debounced 0->1 edge.
module debouncer
    import start_ctrl_pkg::*;
#(
    parameter int CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic rise
);
    localparam int CW = $clog2(CYCLES + 1);
    logic [1:0]    sync;
    logic [1:0]    fill;
    logic [CW-1:0] cnt;
    logic          dout_q;
    logic          armed;
    // A level already high when reset releases must be seen low once before it can count as a press
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync   <= '0;
            fill   <= '0;
            cnt    <= '0;
            dout   <= 1'b0;
            dout_q <= 1'b0;
            rise   <= 1'b0;
            armed  <= 1'b0;
        end else begin
            sync   <= {sync[0], din};
            fill   <= {fill[0], 1'b1};
            armed  <= armed | (fill[1] & ~sync[1]);
            dout_q <= dout;
            rise   <= dout & ~dout_q & armed;
            if (sync[1] == dout)
                cnt <= '0;
            else if (cnt == CW'(CYCLES - 1)) begin
                dout <= sync[1];
                cnt  <= '0;
            end else
                cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/start_ctrl.sv
// start_ctrl: push-button start sequencer with run watchdog and completed-run counter.
module start_ctrl
    import start_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             switch,
    input  logic             all_done,
    output logic             start,
    output logic             busy,
    output logic             done_flag,
    output logic             timeout,
    output logic [CNT_W-1:0] run_count
);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [1:0]    rst_sync;
    logic          rst_n;
    logic          sw_level;
    logic          sw_rise;
    logic          press;
    state_t        state;
    logic [WW-1:0] wd;
    // Asserts immediately with reset, releases two clocks later
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            rst_sync <= '0;
        else
            rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];
    debouncer #(.CYCLES(DEBOUNCE_CYCLES)) u_debouncer (
        .clk  (clk),
        .reset(rst_n),
        .din  (switch),
        .dout (sw_level),
        .rise (sw_rise)
    );
    assign press = sw_rise & sw_level;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            wd        <= '0;
            done_flag <= 1'b0;
            timeout   <= 1'b0;
            run_count <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE:
                    if (press) begin
                        state     <= S_START;
                        done_flag <= 1'b0;
                        timeout   <= 1'b0;
                    end
                S_START: begin
                    state <= S_RUN;
                    wd    <= '0;
                end
                // Completion takes priority over a watchdog expiry in the same cycle
                S_RUN:
                    if (all_done) begin
                        state     <= S_DONE;
                        done_flag <= 1'b1;
                        run_count <= run_count + 1'b1;
                    end else if (wd == WW'(TIMEOUT_CYCLES - 1)) begin
                        state   <= S_ERR;
                        timeout <= 1'b1;
                    end else
                        wd <= wd + 1'b1;
                S_ERR:
                    if (press) begin
                        state   <= S_IDLE;
                        timeout <= 1'b0;
                    end
                default: state <= S_IDLE;
            endcase
        end
    end
    assign start = (state == S_START);
    assign busy  = (state == S_START) || (state == S_RUN);
endmodule
